pulse_train_sequencer: RTL and testbench

PULSE_TRAIN_SEQUENCER -- requirements
Module: pulse_train_sequencer

---
 rtl/pulse_train_sequencer.sv | 129 ++++++++++++
 tb/tb_pulse_train_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pulse_train_sequencer.sv
// Pulse train generator: emits `repeats` low/high pairs with programmable phase
// lengths, plus busy/done status and single-cycle edge strobes on the waveform.
module pulse_train_sequencer #(
    parameter int CNT_W = 8,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [REP_W-1:0] repeats,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic             rise,
    output logic             fall,
    output logic [REP_W-1:0] pulse_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REP_W:0]   REP_ONE = {{REP_W{1'b0}}, 1'b1};

    state_t           state, state_next;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] low_q, high_q;
    logic [REP_W-1:0] rep_q;
    logic             out_d;
    logic [REP_W:0]   pc_inc;
    logic             launch;

    // The counter holds remaining cycles minus one, so a zero length collapses to one cycle.
    function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_ONE;
    endfunction

    assign launch = start && !abort;
    assign pc_inc = {1'b0, pulse_count} + REP_ONE;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (launch) state_next = (repeats == '0) ? S_DONE : S_LOW;
            S_LOW: begin
                if (abort)                state_next = S_IDLE;
                else if (phase_cnt == '0) state_next = S_HIGH;
            end
            S_HIGH: begin
                if (abort)                state_next = S_IDLE;
                else if (phase_cnt == '0) state_next = (pc_inc < {1'b0, rep_q}) ? S_LOW : S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == S_LOW) || (state == S_HIGH);
        done      = (state == S_DONE);
        rise      = out && !out_d;
        fall      = !out && out_d;
        state_dbg = state;
    end

    // Waveform register follows the next state so it lines up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= 1'b0;
            out_d <= 1'b0;
        end else begin
            out   <= (state_next == S_HIGH);
            out_d <= out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_cnt   <= '0;
            low_q       <= '0;
            high_q      <= '0;
            rep_q       <= '0;
            pulse_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        low_q       <= low_cycles;
                        high_q      <= high_cycles;
                        rep_q       <= repeats;
                        pulse_count <= '0;
                        phase_cnt   <= phase_load(low_cycles);
                    end
                end
                S_LOW: begin
                    if (!abort) begin
                        if (phase_cnt == '0) phase_cnt <= phase_load(high_q);
                        else                 phase_cnt <= phase_cnt - CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!abort) begin
                        if (phase_cnt == '0) begin
                            pulse_count <= pc_inc[REP_W-1:0];
                            phase_cnt   <= phase_load(low_q);
                        end else begin
                            phase_cnt <= phase_cnt - CNT_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_sequencer.sv
// Directed bench for pulse_train_sequencer; outputs are sampled on the falling edge.
module tb_pulse_train_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:0] low_cycles, high_cycles, repeats;
    logic       out, busy, done, rise, fall;
    logic [7:0] pulse_count;
    logic [1:0] state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pulse_train_sequencer #(.CNT_W(8), .REP_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .low_cycles(low_cycles), .high_cycles(high_cycles), .repeats(repeats),
        .out(out), .busy(busy), .done(done), .rise(rise), .fall(fall),
        .pulse_count(pulse_count), .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag, input logic [7:0] exp_pc);
        check({tag, ".state"}, state_dbg, 0);
        check({tag, ".out"},   out,  0);
        check({tag, ".busy"},  busy, 0);
        check({tag, ".done"},  done, 0);
        check({tag, ".rise"},  rise, 0);
        check({tag, ".fall"},  fall, 0);
        check({tag, ".pc"},    pulse_count, exp_pc);
    endtask

    // Called at a falling edge; returns at the falling edge of the first train cycle.
    task automatic start_train(input logic [7:0] l, input logic [7:0] h, input logic [7:0] r);
        low_cycles  = l;
        high_cycles = h;
        repeats     = r;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Walks a train cycle by cycle against a hand-written out sequence (bit i = cycle i),
    // scrambling config inputs and optionally poking start mid-train, then checks DONE.
    task automatic check_train(input string tag, input logic [31:0] seq, input int len,
                               input logic [7:0] exp_pc, input int poke);
        logic e, prev;
        prev = 1'b0;
        for (int i = 0; i < len; i++) begin
            e = seq[i];
            check({tag, ".out"},  out,  e);
            check({tag, ".rise"}, rise, e & ~prev);
            check({tag, ".fall"}, fall, ~e & prev);
            check({tag, ".busy"}, busy, 1);
            check({tag, ".done"}, done, 0);
            prev        = e;
            start       = (i == poke);
            low_cycles  = 8'($urandom_range(0, 255));
            high_cycles = 8'($urandom_range(0, 255));
            repeats     = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, ".d_out"},  out,  0);
        check({tag, ".d_rise"}, rise, 0);
        check({tag, ".d_fall"}, fall, prev);
        check({tag, ".d_busy"}, busy, 0);
        check({tag, ".d_done"}, done, 1);
        check({tag, ".d_pc"},   pulse_count, exp_pc);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle({tag, ".after"}, exp_pc);
        @(negedge clk);
        check_idle({tag, ".after2"}, exp_pc);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        low_cycles = '0; high_cycles = '0; repeats = '0;
        repeat (2) @(negedge clk);
        check_idle("reset", 0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset", 0);

        // 1/1 x5 alternating
        start_train(8'd1, 8'd1, 8'd5);
        check_train("alt5", 32'b1010101010, 10, 8'd5, -1);

        // 3/2 x2 with a start poked mid-train that must not queue
        start_train(8'd3, 8'd2, 8'd2);
        check_train("l3h2", 32'b1100011000, 10, 8'd2, 4);

        // zero phase lengths behave as one cycle
        start_train(8'd0, 8'd0, 8'd3);
        check_train("zero_len", 32'b101010, 6, 8'd3, -1);

        // zero repeats: straight to DONE, pulse_count cleared from previous train
        start_train(8'd4, 8'd4, 8'd0);
        check_train("rep0", 32'b0, 0, 8'd0, -1);

        // abort in second HIGH: L,L,H,H,H,L,L,H(8),H(9)
        start_train(8'd2, 8'd3, 8'd4);
        repeat (8) @(negedge clk);
        check("abort.pre_out", out, 1);
        check("abort.pre_pc",  pulse_count, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort.out",   out,  0);
        check("abort.fall",  fall, 1);
        check("abort.busy",  busy, 0);
        check("abort.done",  done, 0);
        check("abort.pc",    pulse_count, 1);
        check("abort.state", state_dbg, 0);
        @(negedge clk);
        check_idle("abort.idle", 8'd1);
        start_train(8'd1, 8'd1, 8'd1);
        check_train("restart", 32'b10, 2, 8'd1, -1);

        // reset during second HIGH of a 1/1 x3 train (pulse_count already 1)
        start_train(8'd1, 8'd1, 8'd3);
        repeat (3) @(negedge clk);
        check("rst.pre_out", out, 1);
        check("rst.pre_pc",  pulse_count, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst.mid", 0);
        @(negedge clk);
        check_idle("rst.after", 0);

        // start together with abort in IDLE: abort wins
        low_cycles = 8'd1; high_cycles = 8'd1; repeats = 8'd2;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_idle("start_abort", 0);
        @(negedge clk);
        check_idle("start_abort2", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
